// File: rtl/bus_stack_pkg.sv
// Shared definitions for the bus register family: default bus width, counter sizing and
// the helper that zero-extends a register value onto the bus.
package bus_stack_pkg;

    localparam int unsigned BusWidthDef = 8;
    localparam int unsigned MaxBusWidth = 32;

    // Counter wide enough to hold the value depth itself, not just depth-1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [MaxBusWidth-1:0] zext_to_bus(input logic [MaxBusWidth-1:0] v,
                                                           input int unsigned w);
        logic [MaxBusWidth-1:0] mask;
        mask = (w >= MaxBusWidth) ? '1 : ((MaxBusWidth'(1) << w) - MaxBusWidth'(1));
        return v & mask;
    endfunction

endpackage

// File: rtl/bus_stack_ptr.sv
// Saturating stack pointer: holds the entry count and derives empty/full.
module bus_stack_ptr
    import bus_stack_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [CW-1:0] count_q, count_d;
    logic          inc, dec;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // Push+pop on an empty stack degenerates to a plain push; otherwise it is a replace.
    assign inc = push_i & (pop_i ? empty_o : ~full_o);
    assign dec = pop_i & ~push_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + CW'(1);
        end else if (dec) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bus_stack.sv
// LIFO register stack on the shared tristate CPU bus.
// Optional sticky overflow/underflow flag (err, err_clr) enabled by BUS_STACK_ERR_EN.
module bus_stack
    import bus_stack_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BUS_WIDTH = BusWidthDef
) (
    input  logic                       clk,
    input  logic                       rst,
    inout  wire  [BUS_WIDTH-1:0]       bus,
    input  logic                       enable,
    input  logic                       push,
    input  logic                       pop,
`ifdef BUS_STACK_ERR_EN
    input  logic                       err_clr,
    output logic                       err,
`endif
    output logic [WIDTH-1:0]           top,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [AW-1:0]        top_idx, wr_idx;
    logic                 replace, we;
    logic [BUS_WIDTH-1:0] bus_drive;

    bus_stack_ptr #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ptr (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    assign top_idx = AW'(count - CW'(1));
    assign replace = push & pop & ~empty;
    assign we      = ~rst & push & (replace | ~full);
    assign wr_idx  = replace ? top_idx : AW'(count);

    // Storage needs no reset: every readable entry is written before count covers it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= bus[WIDTH-1:0];
        end
    end

    assign top       = empty ? '0 : mem_q[top_idx];
    assign bus_drive = BUS_WIDTH'(zext_to_bus(MaxBusWidth'(top), WIDTH));
    assign bus       = enable ? bus_drive : {BUS_WIDTH{1'bz}};

`ifdef BUS_STACK_ERR_EN
    logic err_q, err_d, ignored;

    assign ignored = (push & ~pop & full) | (pop & ~push & empty);

    // A new overflow/underflow in the same cycle takes priority over the clear.
    always_comb begin
        err_d = err_q;
        if (ignored) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_bus_stack.sv
// Directed self-checking bench for bus_stack: default instance plus a WIDTH=4 instance.
module tb_bus_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance (WIDTH=8, DEPTH=16)
    logic       rst, enable, push, pop, drv_en;
    logic [7:0] drv;
    wire  [7:0] bus;
    logic [7:0] top;
    logic [4:0] count;
    logic       empty, full;
`ifdef BUS_STACK_ERR_EN
    logic       err, err_clr;
`endif

    assign bus = drv_en ? drv : 8'hzz;

    bus_stack #(.WIDTH(8), .DEPTH(16), .BUS_WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .enable (enable),
        .push   (push),
        .pop    (pop),
`ifdef BUS_STACK_ERR_EN
        .err_clr(err_clr),
        .err    (err),
`endif
        .top    (top),
        .count  (count),
        .empty  (empty),
        .full   (full)
    );

    // Narrow instance (WIDTH=4)
    logic       rst2, enable2, push2, pop2, drv_en2;
    logic [7:0] drv2;
    wire  [7:0] bus2;
    logic [3:0] top2;
    logic [4:0] count2;
    logic       empty2, full2;
`ifdef BUS_STACK_ERR_EN
    logic       err2;
    logic       err_clr2 = 1'b0;
`endif

    assign bus2 = drv_en2 ? drv2 : 8'hzz;

    bus_stack #(.WIDTH(4), .DEPTH(16), .BUS_WIDTH(8)) dut2 (
        .clk    (clk),
        .rst    (rst2),
        .bus    (bus2),
        .enable (enable2),
        .push   (push2),
        .pop    (pop2),
`ifdef BUS_STACK_ERR_EN
        .err_clr(err_clr2),
        .err    (err2),
`endif
        .top    (top2),
        .count  (count2),
        .empty  (empty2),
        .full   (full2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable = 1'b0; push = 1'b0; pop = 1'b0; drv_en = 1'b0; drv = 8'h00;
`ifdef BUS_STACK_ERR_EN
        err_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_val(input logic [7:0] v);
        idle();
        push = 1'b1; drv_en = 1'b1; drv = v;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        push = 1'b1; drv_en = 1'b1; drv = 8'h42;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || top !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b top=%h, want 0 1 0 00",
                     count, empty, full, top);
        end
`ifdef BUS_STACK_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: err=%b want 0", err);
        end
`endif
        enable = 1'b1;
        #1;
        checks++;
        if (bus !== 8'h00) begin
            errors++;
            $display("FAIL empty_drive: bus=%h want 00", bus);
        end
        // With enable low the bench's own drive must be seen unaltered.
        enable = 1'b0; drv_en = 1'b1; drv = 8'h5A;
        #1;
        checks++;
        if (bus !== 8'h5A) begin
            errors++;
            $display("FAIL release_bus: bus=%h want 5a", bus);
        end
        idle();
    endtask

    task automatic test_push_pop();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'hC3; exp_seq[1] = 8'hB2; exp_seq[2] = 8'hA1;
        do_reset();
        push_val(8'hA1);
        push_val(8'hB2);
        push_val(8'hC3);
        checks++;
        if (count !== 5'd3 || top !== 8'hC3) begin
            errors++;
            $display("FAIL push3: count=%0d top=%h, want 3 c3", count, top);
        end
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1; pop = 1'b1;
            #1;
            checks++;
            if (bus !== exp_seq[i]) begin
                errors++;
                $display("FAIL pop_read[%0d]: bus=%h want %h", i, bus, exp_seq[i]);
            end
            tick();
        end
        idle();
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL drained: empty=%b count=%0d, want 1 0", empty, count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) push_val(8'(8'h10 + i));
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || top !== 8'h1F) begin
            errors++;
            $display("FAIL overflow: count=%0d full=%b top=%h, want 16 1 1f", count, full, top);
        end
`ifdef BUS_STACK_ERR_EN
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_err: err=%b want 1", err);
        end
        err_clr = 1'b1;
        tick();
        idle();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: err=%b want 0", err);
        end
`endif
        // Replace-top stays legal on a full stack.
        push = 1'b1; pop = 1'b1; drv_en = 1'b1; drv = 8'hAB;
        tick();
        idle();
        checks++;
        if (count !== 5'd16 || top !== 8'hAB || full !== 1'b1) begin
            errors++;
            $display("FAIL replace_full: count=%0d top=%h full=%b, want 16 ab 1",
                     count, top, full);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        pop = 1'b1;
        tick();
        idle();
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || top !== 8'h00) begin
            errors++;
            $display("FAIL underflow: count=%0d empty=%b top=%h, want 0 1 00", count, empty, top);
        end
`ifdef BUS_STACK_ERR_EN
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL underflow_err: err=%b want 1", err);
        end
`endif
    endtask

    task automatic test_replace();
        do_reset();
        push_val(8'h11);
        push_val(8'h22);
        push = 1'b1; pop = 1'b1; drv_en = 1'b1; drv = 8'h99;
        tick();
        idle();
        checks++;
        if (count !== 5'd2 || top !== 8'h99) begin
            errors++;
            $display("FAIL replace: count=%0d top=%h, want 2 99", count, top);
        end
        pop = 1'b1;
        tick();
        idle();
        enable = 1'b1;
        #1;
        checks++;
        if (bus !== 8'h11 || count !== 5'd1) begin
            errors++;
            $display("FAIL after_pop: bus=%h count=%0d, want 11 1", bus, count);
        end
        // Self-loop: the stack's own drive is pushed back as a new entry.
        push = 1'b1;
        tick();
        idle();
        checks++;
        if (count !== 5'd2 || top !== 8'h11) begin
            errors++;
            $display("FAIL self_loop: count=%0d top=%h, want 2 11", count, top);
        end
    endtask

    task automatic test_width4();
        enable2 = 1'b0; push2 = 1'b0; pop2 = 1'b0; drv_en2 = 1'b0; drv2 = 8'h00;
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        push2 = 1'b1; drv_en2 = 1'b1; drv2 = 8'hF7;
        tick();
        push2 = 1'b0; drv_en2 = 1'b0;
        checks++;
        if (top2 !== 4'h7 || count2 !== 5'd1) begin
            errors++;
            $display("FAIL w4_push: top=%h count=%0d, want 7 1", top2, count2);
        end
        enable2 = 1'b1;
        #1;
        checks++;
        if (bus2 !== 8'h07) begin
            errors++;
            $display("FAIL w4_drive: bus=%h want 07", bus2);
        end
        enable2 = 1'b0;
        rst2 = 1'b1; push2 = 1'b1; drv_en2 = 1'b1; drv2 = 8'h3C;
        tick();
        rst2 = 1'b0; push2 = 1'b0; drv_en2 = 1'b0;
        checks++;
        if (count2 !== 5'd0 || empty2 !== 1'b1) begin
            errors++;
            $display("FAIL w4_rst_push: count=%0d empty=%b, want 0 1", count2, empty2);
        end
    endtask

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        enable2 = 1'b0; push2 = 1'b0; pop2 = 1'b0; drv_en2 = 1'b0; drv2 = 8'h00;
        idle();
        tick();
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
